// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Elastic valid/ready pipeline-stage register carrying NUM_FIELDS
//            packed words, with flush and a saturating stall-cycle counter.
//            Define PIPE_SKID_BUF_EN to add a 1-entry skid buffer and a fully
//            registered o_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FIELDS = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [DATA_WIDTH*NUM_FIELDS-1:0] i_data,
    input  logic                             i_flush,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [DATA_WIDTH*NUM_FIELDS-1:0] o_data,
    output logic [CNT_WIDTH-1:0]             o_stall_cnt
);

    localparam int                   c_bus_width = DATA_WIDTH * NUM_FIELDS;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                   r_out_valid;
    logic [c_bus_width-1:0] r_out_data;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;
    logic                   w_in_xfer;

`ifdef PIPE_SKID_BUF_EN
    logic                   r_skid_valid;
    logic [c_bus_width-1:0] r_skid_data;
    logic                   w_out_free;

    // Ready depends only on skid occupancy, so i_ready never reaches o_ready.
    assign o_ready    = !r_skid_valid;
    assign w_in_xfer  = i_valid && !r_skid_valid;
    assign w_out_free = !r_out_valid || i_ready;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_free) begin
            // A full skid implies no input was accepted this cycle.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end
`else
    assign o_ready   = !r_out_valid || i_ready;
    assign w_in_xfer = i_valid && o_ready;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_data;
        end else if (i_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // Profiling counter survives flushes; only reset clears it.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !i_ready && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign o_valid     = r_out_valid;
    assign o_data      = r_out_data;
    assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
